// File: rtl/dmem_ws.sv
// Wait-state data memory: 32-bit words, byte/half/word loads and stores with
// programmable access latency and misalignment reporting.
module dmem_ws #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        done,
  output logic [31:0] rd,
  output logic        misalign
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        a_q;
  logic [31:0]        wd_q;
  logic               we_q;
  logic               sext_q;
  logic [1:0]         size_q;
  logic [31:0]        mem [DEPTH];

  logic               accept_c;
  logic               access_c;
  logic               mis_c;
  logic [ADDR_W-1:0]  idx_c;
  logic [31:0]        word_c;
  logic [31:0]        load_c;
  logic [31:0]        wdat_c;
  logic [3:0]         be_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;

  // Next-state logic; the access itself happens on the edge leaving WAIT.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    access_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept_c  = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          access_c  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ready = reset_n && (state == S_IDLE);

  // Lane selection, alignment check and store merge, all from latched operands.
  always_comb begin
    idx_c  = a_q[ADDR_W+1:2];
    word_c = mem[idx_c];
    mis_c  = (size_q == 2'b11) ||
             ((size_q == 2'b01) && a_q[0]) ||
             ((size_q == 2'b10) && (a_q[1:0] != 2'b00));
    byte_c = 8'(word_c >> {a_q[1:0], 3'b000});
    half_c = a_q[1] ? word_c[31:16] : word_c[15:0];
    load_c = word_c;
    wdat_c = wd_q;
    be_c   = 4'b1111;
    case (size_q)
      2'b00: begin
        load_c = sext_q ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
        wdat_c = {4{wd_q[7:0]}};
        be_c   = 4'(4'b0001 << a_q[1:0]);
      end
      2'b01: begin
        load_c = sext_q ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
        wdat_c = {2{wd_q[15:0]}};
        be_c   = a_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_c = word_c;
        wdat_c = wd_q;
        be_c   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      misalign <= 1'b0;
      rd       <= '0;
    end else begin
      state    <= state_nxt;
      done     <= access_c;
      misalign <= access_c && mis_c;
      rd       <= (access_c && !we_q && !mis_c) ? load_c : 32'd0;
      if (accept_c)
        cnt <= CNT_W'(WAIT_CYC);
      else if ((state == S_WAIT) && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
    end
  end

  // Operand latches need no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (reset_n && accept_c) begin
      a_q    <= a;
      wd_q   <= wd;
      we_q   <= we;
      sext_q <= sext;
      size_q <= size;
    end
  end

  // Memory contents survive reset; a reset cycle never commits a write.
  always_ff @(posedge clk) begin
    if (reset_n && access_c && we_q && !mis_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_c[k])
          mem[idx_c][8*k +: 8] <= wdat_c[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws: one instance with WAIT_CYC=2, one with WAIT_CYC=0.
module tb_dmem_ws;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] a;
  logic [31:0] wd;
  logic        sel;

  logic        req0, ready0, done0, mis0;
  logic        req1, ready1, done1, mis1;
  logic [31:0] rd0, rd1;
  logic        rdy_s, done_s, mis_s;
  logic [31:0] rd_s;

  int vecs = 0;
  int errs = 0;

  logic [31:0] r;
  logic        m;

  always #5 clk = ~clk;

  assign req0   = req & ~sel;
  assign req1   = req & sel;
  assign rdy_s  = sel ? ready1 : ready0;
  assign done_s = sel ? done1  : done0;
  assign mis_s  = sel ? mis1   : mis0;
  assign rd_s   = sel ? rd1    : rd0;

  dmem_ws #(.ADDR_W(6), .WAIT_CYC(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req0), .we(we), .size(size),
    .sext(sext), .a(a), .wd(wd), .ready(ready0), .done(done0),
    .rd(rd0), .misalign(mis0)
  );

  dmem_ws #(.ADDR_W(6), .WAIT_CYC(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .we(we), .size(size),
    .sext(sext), .a(a), .wd(wd), .ready(ready1), .done(done1),
    .rd(rd1), .misalign(mis1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One access on the selected instance; inputs are scrambled after accept.
  task automatic access(input logic iwe, input logic [1:0] isz, input logic isx,
                        input logic [31:0] ia, input logic [31:0] iwd, input bit poke,
                        output logic [31:0] ord, output logic omis);
    int n;
    n = 0;
    while (!rdy_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(rdy_s), 32'd1);
    we = iwe; size = isz; sext = isx; a = ia; wd = iwd; req = 1'b1;
    @(negedge clk);
    req = 1'b0; we = ~iwe; size = ~isz; sext = ~isx; a = ~ia; wd = ~iwd;
    if (poke) req = 1'b1;
    n = 1;
    while (!done_s && n < 20) begin
      @(negedge clk);
      req = 1'b0;
      n++;
    end
    chk("done_latency", 32'(n), sel ? 32'd2 : 32'd4);
    ord  = rd_s;
    omis = mis_s;
    @(negedge clk);
    req = 1'b0;
    chk("done_one_cycle", 32'(done_s), 32'd0);
    chk("rd_zero_idle", rd_s, 32'd0);
  endtask

  initial begin
    sel = 1'b0; reset_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10;
    sext = 1'b0; a = '0; wd = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_rd", rd0, 32'd0);
    chk("rst_mis", 32'(mis0), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready0), 32'd1);

    // Word store then load
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, r, m);
    chk("st_word_rd", r, 32'd0);
    chk("st_word_mis", 32'(m), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r, m);
    chk("ld_word", r, 32'hDEADBEEF);
    chk("ld_word_mis", 32'(m), 32'd0);

    // Byte and half lanes
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF80, 1'b0, r, m);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, r, m);
    chk("ld_byte_sext", r, 32'hFFFFFF80);
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, r, m);
    chk("ld_byte_zext", r, 32'h00000080);
    access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, r, m);
    chk("ld_word_after_byte", r, 32'hDEAD80EF);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, r, m);
    chk("ld_half_sext", r, 32'hFFFFDEAD);
    access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, r, m);
    chk("ld_half_zext", r, 32'h000080EF);

    // Misalignment
    access(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1'b0, r, m);
    chk("mis_st_flag", 32'(m), 32'd1);
    chk("mis_st_rd", r, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r, m);
    chk("mis_st_no_write", r, 32'hDEAD80EF);
    access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b0, r, m);
    chk("mis_half_flag", 32'(m), 32'd1);
    chk("mis_half_rd", r, 32'd0);
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, r, m);
    chk("mis_size3_flag", 32'(m), 32'd1);
    chk("mis_size3_rd", r, 32'd0);

    // Address wrap, and a req pulse during WAIT must be dropped
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'hA5A5A5A5, 1'b1, r, m);
    for (int i = 0; i < 4; i++) begin
      chk("no_extra_done", 32'(done0), 32'd0);
      @(negedge clk);
    end
    access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0, r, m);
    chk("wrap_load", r, 32'hA5A5A5A5);

    // Reset mid-access aborts the store
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, r, m);
    chk("pre_rst_ready", 32'(ready0), 32'd1);
    we = 1'b1; size = 2'b10; a = 32'h20; wd = 32'h0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(ready0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_done", 32'(done0), 32'd0);
      chk("rst_mid_ready_hold", 32'(ready0), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 32'(ready0), 32'd1);
    chk("rst_rel_done", 32'(done0), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, r, m);
    chk("rst_no_commit", r, 32'h11223344);

    // Zero wait states
    sel = 1'b1;
    @(negedge clk);
    access(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D, 1'b0, r, m);
    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, r, m);
    chk("w0_load", r, 32'hCAFEF00D);
    access(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 1'b0, r, m);
    chk("w0_byte3_sext", r, 32'hFFFFFFCA);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
